// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types for the instruction-ROM port arbiter
package rom_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  // Low address bits that must be zero for a word-aligned fetch.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant between IF and MEM
// Pointer favours IF out of reset; flips to the other side on every taken grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_if_i,
  input  logic req_mem_i,
  input  logic take_i,
  output logic gnt_if_o,
  output logic gnt_mem_o
);

  logic prio_mem_q;
  logic prio_mem_d;

  always_comb begin
    gnt_if_o   = req_if_i && (!req_mem_i || !prio_mem_q);
    gnt_mem_o  = req_mem_i && (!req_if_i || prio_mem_q);
    prio_mem_d = prio_mem_q;
    if (take_i && gnt_if_o) begin
      prio_mem_d = 1'b1;
    end else if (take_i && gnt_mem_o) begin
      prio_mem_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_mem_q <= 1'b0;
    end else begin
      prio_mem_q <= prio_mem_d;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares the single-port instruction ROM between IF and MEM
// Optional IF flush port and kill logic under `ROM_ARB_FLUSH_EN.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ROM_DEPTH = 128,
  parameter int ROM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ROM_ARB_FLUSH_EN
  input  logic              if_flush,
`endif
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              if_rsp_ready,
  input  logic              mem_req_valid,
  input  logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_ready,
  output logic              mem_rsp_valid,
  output logic [DATA_W-1:0] mem_rsp_data,
  output logic              mem_rsp_err,
  input  logic              mem_rsp_ready,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [ADDR_W:0] ROM_BYTES = (ADDR_W+1)'(ROM_DEPTH * 4);
  localparam logic [1:0]      CNT_LOAD  = 2'(ROM_LAT - 1);

  state_e            state_q;
  owner_e            owner_q;
  logic [1:0]        cnt_q;
  logic              killed_q;
  logic              rom_ce_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              if_rsp_valid_q, mem_rsp_valid_q;
  logic              if_rsp_err_q, mem_rsp_err_q;
  logic [DATA_W-1:0] if_rsp_data_q, mem_rsp_data_q;

  logic              flush_if;
  logic              gnt_if, gnt_mem;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_legal;
  logic              kill_now;
  logic              owner_ready;

`ifdef ROM_ARB_FLUSH_EN
  assign flush_if = if_flush;
`else
  assign flush_if = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req_if_i  (if_req_valid && !flush_if),
    .req_mem_i (mem_req_valid),
    .take_i    (state_q == IDLE),
    .gnt_if_o  (gnt_if),
    .gnt_mem_o (gnt_mem)
  );

  assign if_req_ready  = rst && (state_q == IDLE) && gnt_if;
  assign mem_req_ready = rst && (state_q == IDLE) && gnt_mem;

  assign sel_addr    = gnt_mem ? mem_req_addr : if_req_addr;
  assign sel_legal   = ((sel_addr[1:0] & ALIGN_MASK) == 2'b00) && ({1'b0, sel_addr} < ROM_BYTES);
  assign kill_now    = killed_q || (flush_if && (owner_q == OWN_IF));
  assign owner_ready = (owner_q == OWN_IF) ? if_rsp_ready : mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      owner_q         <= OWN_IF;
      cnt_q           <= 2'd0;
      killed_q        <= 1'b0;
      rom_ce_q        <= 1'b0;
      rom_addr_q      <= '0;
      if_rsp_valid_q  <= 1'b0;
      mem_rsp_valid_q <= 1'b0;
      if_rsp_err_q    <= 1'b0;
      mem_rsp_err_q   <= 1'b0;
      if_rsp_data_q   <= '0;
      mem_rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_if || gnt_mem) begin
            owner_q  <= gnt_mem ? OWN_MEM : OWN_IF;
            killed_q <= 1'b0;
            if (sel_legal) begin
              rom_ce_q   <= 1'b1;
              rom_addr_q <= sel_addr;
              cnt_q      <= CNT_LOAD;
              state_q    <= WAIT;
            end else if (gnt_mem) begin
              mem_rsp_valid_q <= 1'b1;
              mem_rsp_err_q   <= 1'b1;
              mem_rsp_data_q  <= '0;
              state_q         <= RESP;
            end else begin
              if_rsp_valid_q <= 1'b1;
              if_rsp_err_q   <= 1'b1;
              if_rsp_data_q  <= '0;
              state_q        <= RESP;
            end
          end
        end
        WAIT: begin
          killed_q <= kill_now;
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            rom_ce_q <= 1'b0;
            // A flushed fetch still lets the ROM cycle finish, then vanishes.
            if (kill_now) begin
              state_q <= IDLE;
            end else if (owner_q == OWN_MEM) begin
              mem_rsp_valid_q <= 1'b1;
              mem_rsp_err_q   <= 1'b0;
              mem_rsp_data_q  <= rom_data;
              state_q         <= RESP;
            end else begin
              if_rsp_valid_q <= 1'b1;
              if_rsp_err_q   <= 1'b0;
              if_rsp_data_q  <= rom_data;
              state_q        <= RESP;
            end
          end
        end
        RESP: begin
          if (owner_ready || (flush_if && (owner_q == OWN_IF))) begin
            if (owner_q == OWN_MEM) begin
              mem_rsp_valid_q <= 1'b0;
            end else begin
              if_rsp_valid_q <= 1'b0;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_ce        = rom_ce_q;
  assign rom_addr      = rom_addr_q;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_data   = if_rsp_data_q;
  assign if_rsp_err    = if_rsp_err_q;
  assign mem_rsp_valid = mem_rsp_valid_q;
  assign mem_rsp_data  = mem_rsp_data_q;
  assign mem_rsp_err   = mem_rsp_err_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed bench for rom_port_arbiter at ROM_LAT 1 and 3
module tb_rom_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // ROM contents: word n holds 0xC0DE0000 + n.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC0DE0000 + (a >> 2);
  endfunction

  logic        a_if_flush, a_if_req_valid, a_if_req_ready, a_if_rsp_valid, a_if_rsp_err, a_if_rsp_ready;
  logic        a_mem_req_valid, a_mem_req_ready, a_mem_rsp_valid, a_mem_rsp_err, a_mem_rsp_ready, a_rom_ce;
  logic [31:0] a_if_req_addr, a_if_rsp_data, a_mem_req_addr, a_mem_rsp_data, a_rom_addr, a_rom_data;
  logic        b_if_flush, b_if_req_valid, b_if_req_ready, b_if_rsp_valid, b_if_rsp_err, b_if_rsp_ready;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_rsp_valid, b_mem_rsp_err, b_mem_rsp_ready, b_rom_ce;
  logic [31:0] b_if_req_addr, b_if_rsp_data, b_mem_req_addr, b_mem_rsp_data, b_rom_addr, b_rom_data;

  assign a_rom_data = rom_word(a_rom_addr);
  assign b_rom_data = rom_word(b_rom_addr);

  rom_port_arbiter #(.ROM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
`ifdef ROM_ARB_FLUSH_EN
    .if_flush(a_if_flush),
`endif
    .if_req_valid(a_if_req_valid), .if_req_addr(a_if_req_addr), .if_req_ready(a_if_req_ready),
    .if_rsp_valid(a_if_rsp_valid), .if_rsp_data(a_if_rsp_data), .if_rsp_err(a_if_rsp_err),
    .if_rsp_ready(a_if_rsp_ready),
    .mem_req_valid(a_mem_req_valid), .mem_req_addr(a_mem_req_addr), .mem_req_ready(a_mem_req_ready),
    .mem_rsp_valid(a_mem_rsp_valid), .mem_rsp_data(a_mem_rsp_data), .mem_rsp_err(a_mem_rsp_err),
    .mem_rsp_ready(a_mem_rsp_ready),
    .rom_ce(a_rom_ce), .rom_addr(a_rom_addr), .rom_data(a_rom_data)
  );

  rom_port_arbiter #(.ROM_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
`ifdef ROM_ARB_FLUSH_EN
    .if_flush(b_if_flush),
`endif
    .if_req_valid(b_if_req_valid), .if_req_addr(b_if_req_addr), .if_req_ready(b_if_req_ready),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data), .if_rsp_err(b_if_rsp_err),
    .if_rsp_ready(b_if_rsp_ready),
    .mem_req_valid(b_mem_req_valid), .mem_req_addr(b_mem_req_addr), .mem_req_ready(b_mem_req_ready),
    .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_data(b_mem_rsp_data), .mem_rsp_err(b_mem_rsp_err),
    .mem_rsp_ready(b_mem_rsp_ready),
    .rom_ce(b_rom_ce), .rom_addr(b_rom_addr), .rom_data(b_rom_data)
  );

  task automatic test_reset;
    rst = 1'b0;
    a_if_req_valid = 1'b1; a_if_req_addr = 32'h0; a_mem_req_valid = 1'b1; a_mem_req_addr = 32'h4;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (a_rom_ce !== 1'b0) begin n_bad++; $display("FAIL reset_rom_ce got %0h want 0", a_rom_ce); end
    n_cmp++; if (a_rom_addr !== 32'h0) begin n_bad++; $display("FAIL reset_rom_addr got %0h want 0", a_rom_addr); end
    n_cmp++; if ({a_if_rsp_valid, a_mem_rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 00", {a_if_rsp_valid, a_mem_rsp_valid}); end
    n_cmp++; if ({a_if_rsp_data, a_if_rsp_err} !== 33'h0) begin n_bad++; $display("FAIL reset_rsp_data_err got %0h want 0", {a_if_rsp_data, a_if_rsp_err}); end
    n_cmp++; if ({a_if_req_ready, a_mem_req_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready got %b want 00", {a_if_req_ready, a_mem_req_ready}); end
    n_cmp++; if (b_rom_ce !== 1'b0) begin n_bad++; $display("FAIL reset_b_rom_ce got %0h want 0", b_rom_ce); end
    a_if_req_valid = 1'b0; a_mem_req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    a_if_req_addr = 32'h8; a_if_req_valid = 1'b1; a_if_rsp_ready = 1'b1; #1;
    n_cmp++; if ({a_if_req_ready, a_mem_req_ready} !== 2'b10) begin n_bad++; $display("FAIL single_accept got %b want 10", {a_if_req_ready, a_mem_req_ready}); end
    @(negedge clk);
    n_cmp++; if ({a_rom_ce, a_rom_addr} !== {1'b1, 32'h8}) begin n_bad++; $display("FAIL single_rom got ce=%0h addr=%0h want ce=1 addr=8", a_rom_ce, a_rom_addr); end
    n_cmp++; if ({a_if_rsp_valid, a_if_req_ready} !== 2'b00) begin n_bad++; $display("FAIL single_wait got %b want 00", {a_if_rsp_valid, a_if_req_ready}); end
    a_if_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({a_if_rsp_valid, a_if_rsp_err, a_mem_rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL single_rsp got %b want 100", {a_if_rsp_valid, a_if_rsp_err, a_mem_rsp_valid}); end
    n_cmp++; if (a_if_rsp_data !== 32'hC0DE0002) begin n_bad++; $display("FAIL single_data got %0h want c0de0002", a_if_rsp_data); end
    n_cmp++; if (a_rom_ce !== 1'b0) begin n_bad++; $display("FAIL single_ce_drop got %0h want 0", a_rom_ce); end
    @(negedge clk);
    n_cmp++; if ({a_if_rsp_valid, a_rom_addr} !== {1'b0, 32'h8}) begin n_bad++; $display("FAIL single_done got v=%0h addr=%0h want v=0 addr=8", a_if_rsp_valid, a_rom_addr); end
  endtask

  task automatic test_back_to_back;
    logic        even;
    logic [31:0] got;
    rst = 1'b0;
    a_if_req_valid = 1'b1; a_if_req_addr = 32'h10; a_mem_req_valid = 1'b1; a_mem_req_addr = 32'h20;
    a_if_rsp_ready = 1'b1; a_mem_rsp_ready = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      even = (k % 2 == 0);
      n_cmp++; if ({a_if_req_ready, a_mem_req_ready} !== {even, !even}) begin n_bad++; $display("FAIL b2b_grant%0d got %b want %b", k, {a_if_req_ready, a_mem_req_ready}, {even, !even}); end
      @(negedge clk);
      n_cmp++; if ({a_if_rsp_valid, a_mem_rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL b2b_wait%0d got %b want 00", k, {a_if_rsp_valid, a_mem_rsp_valid}); end
      @(negedge clk);
      n_cmp++; if ({a_if_rsp_valid, a_mem_rsp_valid} !== {even, !even}) begin n_bad++; $display("FAIL b2b_rsp%0d got %b want %b", k, {a_if_rsp_valid, a_mem_rsp_valid}, {even, !even}); end
      got = even ? a_if_rsp_data : a_mem_rsp_data;
      n_cmp++; if (got !== (even ? 32'hC0DE0004 : 32'hC0DE0008)) begin n_bad++; $display("FAIL b2b_data%0d got %0h want %0h", k, got, even ? 32'hC0DE0004 : 32'hC0DE0008); end
      @(negedge clk); #1;
    end
    a_if_req_valid = 1'b0; a_mem_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err;
    logic [31:0] addrs [3];
    addrs[0] = 32'h6; addrs[1] = 32'h200; addrs[2] = 32'h1FC;
    for (int k = 0; k < 3; k++) begin
      a_if_req_addr = addrs[k]; a_if_req_valid = 1'b1; #1;
      n_cmp++; if (a_if_req_ready !== 1'b1) begin n_bad++; $display("FAIL err_accept%0d got %0h want 1", k, a_if_req_ready); end
      @(negedge clk);
      a_if_req_valid = 1'b0;
      n_cmp++; if (a_rom_ce !== (k == 2)) begin n_bad++; $display("FAIL err_rom_ce%0d got %0h want %0h", k, a_rom_ce, k == 2); end
      if (k == 2) @(negedge clk);
      n_cmp++; if ({a_if_rsp_valid, a_if_rsp_err} !== {1'b1, k != 2}) begin n_bad++; $display("FAIL err_flag%0d got %b want %b", k, {a_if_rsp_valid, a_if_rsp_err}, {1'b1, k != 2}); end
      n_cmp++; if (a_if_rsp_data !== (k == 2 ? 32'hC0DE007F : 32'h0)) begin n_bad++; $display("FAIL err_data%0d got %0h", k, a_if_rsp_data); end
      @(negedge clk);
    end
  endtask

  task automatic test_lat3;
    b_mem_req_addr = 32'h4; b_mem_req_valid = 1'b1; b_mem_rsp_ready = 1'b0; #1;
    n_cmp++; if (b_mem_req_ready !== 1'b1) begin n_bad++; $display("FAIL lat3_accept got %0h want 1", b_mem_req_ready); end
    @(negedge clk);
    b_mem_req_valid = 1'b0; b_if_req_valid = 1'b1; b_if_req_addr = 32'h0; #1;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if ({b_rom_ce, b_rom_addr, b_mem_rsp_valid, b_if_req_ready} !== {1'b1, 32'h4, 2'b00}) begin n_bad++; $display("FAIL lat3_wait%0d got ce=%0h addr=%0h v=%0h rdy=%0h", c, b_rom_ce, b_rom_addr, b_mem_rsp_valid, b_if_req_ready); end
      @(negedge clk);
    end
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if ({b_mem_rsp_valid, b_mem_rsp_err, b_if_req_ready, b_if_rsp_valid, b_rom_ce} !== 5'b10000) begin n_bad++; $display("FAIL lat3_hold%0d got %b want 10000", c, {b_mem_rsp_valid, b_mem_rsp_err, b_if_req_ready, b_if_rsp_valid, b_rom_ce}); end
      n_cmp++; if (b_mem_rsp_data !== 32'hC0DE0001) begin n_bad++; $display("FAIL lat3_data%0d got %0h want c0de0001", c, b_mem_rsp_data); end
      if (c == 5) b_mem_rsp_ready = 1'b1;
      @(negedge clk);
    end
    #1;
    n_cmp++; if ({b_mem_rsp_valid, b_if_req_ready} !== 2'b01) begin n_bad++; $display("FAIL lat3_after got %b want 01", {b_mem_rsp_valid, b_if_req_ready}); end
    b_if_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    b_if_rsp_ready = 1'b1; b_mem_rsp_ready = 1'b1;
    b_mem_req_addr = 32'h8; b_mem_req_valid = 1'b1; #1;
    n_cmp++; if (b_mem_req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_accept got %0h want 1", b_mem_req_ready); end
    @(negedge clk);
    b_if_req_valid = 1'b1; b_if_req_addr = 32'hC; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({b_rom_ce, b_if_rsp_valid, b_mem_rsp_valid, b_if_req_ready, b_mem_req_ready} !== 5'b0) begin n_bad++; $display("FAIL rmid_reset got %b want 00000", {b_rom_ce, b_if_rsp_valid, b_mem_rsp_valid, b_if_req_ready, b_mem_req_ready}); end
    rst = 1'b1; #1;
    n_cmp++; if ({b_if_req_ready, b_mem_req_ready} !== 2'b10) begin n_bad++; $display("FAIL rmid_if_first got %b want 10", {b_if_req_ready, b_mem_req_ready}); end
    @(negedge clk);
    b_if_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({b_if_rsp_valid, b_mem_rsp_valid, b_if_rsp_data} !== {2'b10, 32'hC0DE0003}) begin n_bad++; $display("FAIL rmid_if_rsp got v=%b data=%0h", {b_if_rsp_valid, b_mem_rsp_valid}, b_if_rsp_data); end
    @(negedge clk); #1;
    n_cmp++; if (b_mem_req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_mem_regrant got %0h want 1", b_mem_req_ready); end
    @(negedge clk);
    b_mem_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({b_mem_rsp_valid, b_mem_rsp_data} !== {1'b1, 32'hC0DE0002}) begin n_bad++; $display("FAIL rmid_mem_rsp got v=%0h data=%0h", b_mem_rsp_valid, b_mem_rsp_data); end
    @(negedge clk);
  endtask

`ifdef ROM_ARB_FLUSH_EN
  task automatic test_flush;
    a_if_req_addr = 32'h0; a_if_req_valid = 1'b1; a_if_rsp_ready = 1'b1; a_mem_rsp_ready = 1'b1; #1;
    n_cmp++; if (a_if_req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_accept got %0h want 1", a_if_req_ready); end
    @(negedge clk);
    a_if_req_valid = 1'b0; a_if_flush = 1'b1; a_mem_req_valid = 1'b1; a_mem_req_addr = 32'h4;
    @(negedge clk);
    a_if_flush = 1'b0; #1;
    n_cmp++; if ({a_if_rsp_valid, a_rom_ce, a_mem_req_ready} !== 3'b001) begin n_bad++; $display("FAIL flush_wait got %b want 001", {a_if_rsp_valid, a_rom_ce, a_mem_req_ready}); end
    @(negedge clk);
    a_mem_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_mem_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL flush_mem_rsp got %0h want 1", a_mem_rsp_valid); end
    @(negedge clk);
    a_if_req_valid = 1'b1; a_if_flush = 1'b1; #1;
    n_cmp++; if (a_if_req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_idle got %0h want 0", a_if_req_ready); end
    a_if_flush = 1'b0; #1;
    n_cmp++; if (a_if_req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_idle_release got %0h want 1", a_if_req_ready); end
    @(negedge clk);
    a_if_req_valid = 1'b0; a_if_rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_if_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL flush_resp_pre got %0h want 1", a_if_rsp_valid); end
    a_if_flush = 1'b1;
    @(negedge clk);
    a_if_flush = 1'b0;
    n_cmp++; if (a_if_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_resp got %0h want 0", a_if_rsp_valid); end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b0;
    a_if_flush = 1'b0; a_if_req_valid = 1'b0; a_if_req_addr = '0; a_if_rsp_ready = 1'b0;
    a_mem_req_valid = 1'b0; a_mem_req_addr = '0; a_mem_rsp_ready = 1'b0;
    b_if_flush = 1'b0; b_if_req_valid = 1'b0; b_if_req_addr = '0; b_if_rsp_ready = 1'b0;
    b_mem_req_valid = 1'b0; b_mem_req_addr = '0; b_mem_rsp_ready = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_err;
    test_lat3;
    test_reset_mid;
`ifdef ROM_ARB_FLUSH_EN
    test_flush;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
